fb_line_prefetch: RTL and testbench
===================================

# fb_line_prefetch

Ping-pong line buffer between the framebuffer read port and the palette/VGA output stage, in the `clk_pixel` domain. It fetches each framebuffer row once into a local buffer one source row ahead of display. It then replays that row for all `SCREEN_DIV` screen lines with horizontal pixel replication, which frees the framebuffer read port for most of every line. Outputs are colour indices, plus sync and active signals aligned to them, ready for palette lookup.

## Interface
- `WIDTH`, 512: source row length in pixels, power of 2.
- `HEIGHT`, 384: source rows.
- `SCREEN_DIV`, 2: screen-to-source scale, power of 2, applied on both axes.
- `V_ACTIVE`, 768: active screen lines.
- `DATA_BITS`, 4: colour index width.
- `FB_READ_LATENCY`, 2: framebuffer read latency in cycles, ≥1.
- `DIM_BITS`, `$clog2(WIDTH)`: row and column field width.

Ports:
- `clk_pixel`  in  1  pixel clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vga_x`, `vga_y`  in  12 each  screen coordinates from the timing controller.
- `video_active`, `vga_hsync`, `vga_vsync`  in  1 each  timing controller outputs.
- `fb_read_en`  out  1  framebuffer read strobe.
- `fb_read_addr`  out  2·DIM_BITS  read address, `{row, col}`.
- `fb_read_data`  in  DATA_BITS  read data, valid `FB_READ_LATENCY` cycles after the strobe.
- `pix_index`  out  DATA_BITS  colour index.
- `pix_active`, `pix_hsync`, `pix_vsync`  out  1 each  inputs delayed to align with `pix_index`.
- `fill_busy`  out  1  fill in progress.
- `underrun`  out  1  sticky flag; cleared only by reset.
- `underrun_count`  out  16  see Configuration.

## Operation
- Two buffers of `WIDTH`×`DATA_BITS`. Source row r lives in buffer r[0].
- Display side:
  - `src_row = vga_y / SCREEN_DIV`, `src_col = vga_x / SCREEN_DIV`, both as shifts.
  - Read buffer `src_row[0]` at `src_col`.
  - The buffer read is registered; `pix_index` is driven from that registered data.
  - `pix_index` = 0 whenever the delayed active signal is low.
- Fill trigger is sampled each cycle when `vga_x == 0`:
  - `vga_y == V_ACTIVE` triggers a fill of row 0.
  - `video_active` with `vga_y % SCREEN_DIV == 0` and `src_row < HEIGHT-1` triggers a fill of row `src_row+1`.
  - The last row triggers nothing.
- Fill FSM:
  - IDLE → ISSUE on trigger. Latch the target row and set `col = 0`.
  - ISSUE: `fb_read_en = 1`, `fb_read_addr = {row, col}`, `col++`. After `col == WIDTH-1`, go to DRAIN.
  - DRAIN: wait until the last returning word is written, then go to IDLE.
- Write tracking: a `FB_READ_LATENCY`-deep shift register carries {valid, col, buffer} alongside each read. Write `fb_read_data` into the buffer when the delayed valid is set.
- Trigger in ISSUE or DRAIN (underrun):
  - Set `underrun`.
  - Flush the shift register; in-flight returns are discarded.
  - Restart ISSUE at `col = 0` for the new row in the same cycle.
- `fill_busy` = state ≠ IDLE.

## Timing
- Display path latency is 2 cycles. `pix_*` at cycle t+2 corresponds to `vga_*` and `video_active` at cycle t.
- Fill, with the trigger sampled at cycle T:
  - `fb_read_en` is high on cycles T+1 … T+WIDTH, with col 0 … WIDTH-1.
  - Last buffer write occurs at T+WIDTH+FB_READ_LATENCY.
  - `fill_busy` is high from T+1 through T+WIDTH+FB_READ_LATENCY.
- A fill completes in WIDTH+FB_READ_LATENCY+1 cycles. The line period must exceed this; otherwise every trigger underruns.
- Reset values:
  - All outputs 0. FSM in IDLE. Shift register cleared. `underrun` 0. Counter 0.
  - Buffer contents are not reset and are undefined until the first full fill of each row.
- Reset asserted mid-fill aborts immediately. After release, fills resume at the next trigger. Output is guaranteed correct from the first frame that starts with a row-0 fill.
- A fill writes buffer (r+1)[0] while display reads r[0], so display and fill never touch the same buffer.

## Configuration
- `FB_PREFETCH_STATS_EN` defined:
  - `underrun_count` increments on each underrun event and saturates at 16'hFFFF.
  - Reset value 0.
- `FB_PREFETCH_STATS_EN` undefined:
  - No counter logic; `underrun_count` is tied to 0.
  - The `underrun` flag is always present.

## Test plan
- Row-0 prefetch (WIDTH=512, framebuffer model with data = (addr ^ addr>>9) & 4'hF): drive `vga_x=0`, `vga_y=768` → `fb_read_en` high for exactly 512 cycles with addresses {0,0}…{0,511}, and `fill_busy` drops at T+515.
- Pixel replication: full 1024×768 frame after prefetch → screen (2c, 2r) and (2c+1, 2r+1) both show framebuffer (r, c), 2 cycles after the input. Sync and active outputs equal the inputs delayed by 2.
- Last row: screen line 766 → no `fb_read_en` during that line. Line 767 replays row 383.
- Underrun: bench wraps `vga_x` at 300 → `underrun` = 1, reads restart at {row+1, 0}, no stale write lands in the buffer. With `FB_PREFETCH_STATS_EN`, `underrun_count` equals the trigger count minus one per frame region.
- Reset mid-fill: pull `rst_n` low at col 200 → `fb_read_en`, `fill_busy` and all `pix_*` outputs go to 0 asynchronously. After release, the next trigger starts at col 0.
- Stats saturation: force 65,540 underruns → `underrun_count` holds 16'hFFFF. With the macro undefined, it reads 0 throughout.

Source files
------------

// File: rtl/fb_line_prefetch.sv
// fb_line_prefetch: ping-pong line buffer between the framebuffer read port and
// the palette stage. One source row is fetched ahead of display, then replayed
// for SCREEN_DIV screen lines with horizontal pixel replication.
// Optional: define FB_PREFETCH_STATS_EN for a saturating underrun event counter.
module fb_line_prefetch #(
    parameter int unsigned WIDTH           = 512,
    parameter int unsigned HEIGHT          = 384,
    parameter int unsigned SCREEN_DIV      = 2,
    parameter int unsigned V_ACTIVE        = 768,
    parameter int unsigned DATA_BITS       = 4,
    parameter int unsigned FB_READ_LATENCY = 2,
    parameter int unsigned DIM_BITS        = $clog2(WIDTH)
) (
    input  logic                    clk_pixel,
    input  logic                    rst_n,
    input  logic [11:0]             vga_x,
    input  logic [11:0]             vga_y,
    input  logic                    video_active,
    input  logic                    vga_hsync,
    input  logic                    vga_vsync,
    output logic                    fb_read_en,
    output logic [2*DIM_BITS-1:0]   fb_read_addr,
    input  logic [DATA_BITS-1:0]    fb_read_data,
    output logic [DATA_BITS-1:0]    pix_index,
    output logic                    pix_active,
    output logic                    pix_hsync,
    output logic                    pix_vsync,
    output logic                    fill_busy,
    output logic                    underrun,
    output logic [15:0]             underrun_count
);

    localparam int unsigned SHIFT  = $clog2(SCREEN_DIV);
    localparam int unsigned LAT    = FB_READ_LATENCY;
    localparam int unsigned MEM_AW = DIM_BITS + 1;

    // In-flight read tag travelling alongside each framebuffer read
    typedef struct packed {
        logic                valid;
        logic [DIM_BITS-1:0] col;
        logic                bufsel;
    } wr_tag_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic [DIM_BITS-1:0]    row_q, row_d;
    logic [DIM_BITS-1:0]    col_q, col_d;
    wr_tag_t [LAT-1:0]      sr_q;
    wr_tag_t                wr_in_c;
    logic                   underrun_q;

    logic [11:0]            src_row_c;
    logic [DIM_BITS-1:0]    src_col_c;
    logic                   trig_c;
    logic [DIM_BITS-1:0]    trig_row_c;
    logic                   under_ev_c;
    logic                   wr_en_c;
    logic                   last_wr_c;
    logic [MEM_AW-1:0]      rd_idx_c;
    logic [MEM_AW-1:0]      wr_idx_c;

    logic [DATA_BITS-1:0]   line_mem [2*WIDTH];
    logic [DATA_BITS-1:0]   rd_data_q;
    logic                   act1_q, hs1_q, vs1_q;
    logic                   pix_active_q, pix_hsync_q, pix_vsync_q;
    logic [DATA_BITS-1:0]   pix_index_q;

    assign src_row_c  = vga_y >> SHIFT;
    assign src_col_c  = DIM_BITS'(vga_x >> SHIFT);
    assign under_ev_c = trig_c && (state_q != ST_IDLE);
    assign wr_en_c    = sr_q[LAT-1].valid && !under_ev_c;
    assign last_wr_c  = wr_en_c && (sr_q[LAT-1].col == DIM_BITS'(WIDTH - 1));
    assign wr_in_c    = {rd_en_q, col_q, row_q[0]};
    assign rd_idx_c   = {src_row_c[0], src_col_c};
    assign wr_idx_c   = {sr_q[LAT-1].bufsel, sr_q[LAT-1].col};

    // Fill trigger: row 0 at the first blanking line, else the next source row
    always_comb begin
        trig_c     = 1'b0;
        trig_row_c = '0;
        if (vga_x == 12'd0) begin
            if (vga_y == 12'(V_ACTIVE)) begin
                trig_c     = 1'b1;
                trig_row_c = '0;
            end else if (video_active
                         && ((vga_y & 12'(SCREEN_DIV - 1)) == 12'd0)
                         && (src_row_c < 12'(HEIGHT - 1))) begin
                trig_c     = 1'b1;
                trig_row_c = DIM_BITS'(src_row_c + 12'd1);
            end
        end
    end

    // Fill FSM state and registered control outputs
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
        end
    end

    // Fill FSM next state; a trigger always (re)starts issuing at col 0
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (trig_c) state_d = ST_ISSUE;
            ST_ISSUE: if (trig_c) state_d = ST_ISSUE;
                      else if (col_q == DIM_BITS'(WIDTH - 1)) state_d = ST_DRAIN;
            ST_DRAIN: if (trig_c) state_d = ST_ISSUE;
                      else if (last_wr_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Fill FSM outputs, decoded from the next state so they land registered
    always_comb begin
        rd_en_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Target row / column counter
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (trig_c) begin
            row_d = trig_row_c;
            col_d = '0;
        end else if (state_q == ST_ISSUE) begin
            col_d = col_q + DIM_BITS'(1);
        end
    end

    // Address counter, return-tracking shift register and sticky underrun flag
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            col_q      <= '0;
            sr_q       <= '0;
            underrun_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (under_ev_c) begin
                sr_q       <= '0;
                underrun_q <= 1'b1;
            end else begin
                sr_q[0] <= wr_in_c;
                for (int i = 1; i < int'(LAT); i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end
    end

    // Line buffer: fill writes one half while display reads the other
    always_ff @(posedge clk_pixel) begin
        if (wr_en_c) begin
            line_mem[wr_idx_c] <= fb_read_data;
        end
        rd_data_q <= line_mem[rd_idx_c];
    end

    // Two-stage display pipeline; index blanked outside the active area
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            act1_q       <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            pix_active_q <= 1'b0;
            pix_hsync_q  <= 1'b0;
            pix_vsync_q  <= 1'b0;
            pix_index_q  <= '0;
        end else begin
            act1_q       <= video_active;
            hs1_q        <= vga_hsync;
            vs1_q        <= vga_vsync;
            pix_active_q <= act1_q;
            pix_hsync_q  <= hs1_q;
            pix_vsync_q  <= vs1_q;
            pix_index_q  <= act1_q ? rd_data_q : '0;
        end
    end

`ifdef FB_PREFETCH_STATS_EN
    logic [15:0] ucnt_q;

    // Saturating underrun event counter
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= 16'd0;
        end else if (under_ev_c && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = 16'd0;
`endif

    assign fb_read_en   = rd_en_q;
    assign fb_read_addr = {row_q, col_q};
    assign fill_busy    = busy_q;
    assign underrun     = underrun_q;
    assign pix_index    = pix_index_q;
    assign pix_active   = pix_active_q;
    assign pix_hsync    = pix_hsync_q;
    assign pix_vsync    = pix_vsync_q;

endmodule

// File: tb/tb_fb_line_prefetch.sv
// Directed bench for fb_line_prefetch with a 2-cycle-latency framebuffer model.
module tb_fb_line_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] vga_x, vga_y;
    logic        video_active, vga_hsync, vga_vsync;
    logic        fb_read_en;
    logic [17:0] fb_read_addr;
    logic [3:0]  fb_read_data;
    logic [3:0]  pix_index;
    logic        pix_active, pix_hsync, pix_vsync;
    logic        fill_busy, underrun;
    logic [15:0] underrun_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] fb_p0 = 4'h0, fb_p1 = 4'h0;
    logic seen_en;

    fb_line_prefetch dut (
        .clk_pixel     (clk),
        .rst_n         (rst_n),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .video_active  (video_active),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .fb_read_en    (fb_read_en),
        .fb_read_addr  (fb_read_addr),
        .fb_read_data  (fb_read_data),
        .pix_index     (pix_index),
        .pix_active    (pix_active),
        .pix_hsync     (pix_hsync),
        .pix_vsync     (pix_vsync),
        .fill_busy     (fill_busy),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] fbd(input logic [17:0] a);
        logic [17:0] t;
        t = a ^ (a >> 9);
        return t[3:0];
    endfunction

    function automatic logic [31:0] addr_of(input int row, input int col);
        return 32'((row << 9) | col);
    endfunction

    function automatic logic [3:0] px(input int row, input int col);
        return fbd(18'(addr_of(row, col)));
    endfunction

    // Framebuffer: data for the address strobed at cycle c appears at c+2
    always @(posedge clk) begin
        fb_p0 <= fbd(fb_read_addr);
        fb_p1 <= fb_p0;
    end
    assign fb_read_data = fb_p1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        vga_x = 12'd1; vga_y = 12'd1;
        video_active = 1'b0; vga_hsync = 1'b0; vga_vsync = 1'b0;
    endtask

    task automatic set_trig(input int y);
        vga_x = 12'd0; vga_y = 12'(y);
        video_active = (y < 768); vga_hsync = 1'b0; vga_vsync = 1'b0;
    endtask

    // Present one vector for a single cycle, then check the outputs 2 cycles later
    task automatic pix_chk(input string tag, input int x, input int y,
                           input logic act, input logic hs, input logic vs,
                           input logic [3:0] exp_idx);
        vga_x = 12'(x); vga_y = 12'(y);
        video_active = act; vga_hsync = hs; vga_vsync = vs;
        step();
        set_idle();
        step();
        chk({tag, "_idx"}, 32'(pix_index), act ? 32'(exp_idx) : 32'd0);
        chk({tag, "_act"}, 32'(pix_active), 32'(act));
        chk({tag, "_hs"},  32'(pix_hsync),  32'(hs));
        chk({tag, "_vs"},  32'(pix_vsync),  32'(vs));
    endtask

    logic [15:0] exp_cnt1, exp_sat;

    initial begin
`ifdef FB_PREFETCH_STATS_EN
        exp_cnt1 = 16'd1;
        exp_sat  = 16'hFFFF;
`else
        exp_cnt1 = 16'd0;
        exp_sat  = 16'd0;
`endif
        rst_n = 1'b0;
        set_idle();
        repeat (3) step();

        // Reset state
        chk("rst_rd_en", 32'(fb_read_en), 0);
        chk("rst_addr", 32'(fb_read_addr), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        chk("rst_pix_index", 32'(pix_index), 0);
        chk("rst_pix_active", 32'(pix_active), 0);
        chk("rst_pix_hsync", 32'(pix_hsync), 0);
        chk("rst_pix_vsync", 32'(pix_vsync), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_count", 32'(underrun_count), 0);
        rst_n = 1'b1;
        step();
        step();

        // Row-0 prefetch from the first blanking line
        set_trig(768);
        step();
        set_idle();
        for (int k = 0; k < 512; k++) begin
            chk($sformatf("pf_en_%0d", k), 32'(fb_read_en), 1);
            chk($sformatf("pf_addr_%0d", k), 32'(fb_read_addr), addr_of(0, k));
            if (k == 0) chk("pf_busy_start", 32'(fill_busy), 1);
            step();
        end
        chk("pf_en_done", 32'(fb_read_en), 0);
        chk("pf_busy_T513", 32'(fill_busy), 1);
        step();
        chk("pf_busy_T514", 32'(fill_busy), 1);
        step();
        chk("pf_busy_T515", 32'(fill_busy), 0);

        // Replication of row 0 on screen lines 0 and 1
        pix_chk("r0c1_e", 2, 0, 1'b1, 1'b1, 1'b0, px(0, 1));
        pix_chk("r0c1_o", 3, 1, 1'b1, 1'b0, 1'b1, px(0, 1));
        pix_chk("r0c6_e", 12, 0, 1'b1, 1'b0, 1'b0, px(0, 6));
        pix_chk("r0c255_o", 511, 1, 1'b1, 1'b1, 1'b1, px(0, 255));
        pix_chk("r0_blank", 12, 0, 1'b0, 1'b1, 1'b1, px(0, 6));

        // Row-1 fill on line 0, replayed on lines 2 and 3
        set_trig(0);
        step();
        set_idle();
        repeat (520) step();
        chk("r1_busy_done", 32'(fill_busy), 0);
        pix_chk("r1c6_e", 12, 2, 1'b1, 1'b0, 1'b0, px(1, 6));
        pix_chk("r1c6_o", 13, 3, 1'b1, 1'b0, 1'b0, px(1, 6));
        pix_chk("r1c511_e", 1022, 2, 1'b1, 1'b0, 1'b0, px(1, 511));
        pix_chk("r0_kept", 13, 1, 1'b1, 1'b0, 1'b0, px(0, 6));

        // Row 383 fetched on line 764; line 766 fetches nothing
        set_trig(764);
        step();
        set_idle();
        chk("r383_en", 32'(fb_read_en), 1);
        chk("r383_addr", 32'(fb_read_addr), addr_of(383, 0));
        repeat (520) step();
        seen_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            vga_x = 12'(i); vga_y = 12'd766; video_active = 1'b1;
            step();
            seen_en |= fb_read_en;
        end
        set_idle();
        chk("last_row_no_read", 32'(seen_en), 0);
        chk("last_row_busy", 32'(fill_busy), 0);
        pix_chk("r383c200_766", 400, 766, 1'b1, 1'b0, 1'b0, px(383, 200));
        pix_chk("r383c6_767", 13, 767, 1'b1, 1'b0, 1'b0, px(383, 6));
        chk("no_underrun_yet", 32'(underrun), 0);

        // Underrun: row-2 fill interrupted at col 100 by a row-3 trigger
        set_trig(2);
        step();
        set_idle();
        repeat (100) step();
        chk("ur_pre_addr", 32'(fb_read_addr), addr_of(2, 100));
        set_trig(4);
        step();
        set_idle();
        chk("ur_flag", 32'(underrun), 1);
        chk("ur_restart_en", 32'(fb_read_en), 1);
        chk("ur_restart_addr", 32'(fb_read_addr), addr_of(3, 0));
        chk("ur_count", 32'(underrun_count), 32'(exp_cnt1));
        repeat (520) step();
        chk("ur_busy_done", 32'(fill_busy), 0);
        pix_chk("ur_c97_new", 194, 0, 1'b1, 1'b0, 1'b0, px(2, 97));
        pix_chk("ur_c98_old", 196, 0, 1'b1, 1'b0, 1'b0, px(0, 98));
        pix_chk("ur_c99_old", 199, 1, 1'b1, 1'b0, 1'b0, px(0, 99));
        pix_chk("ur_r3c5", 11, 7, 1'b1, 1'b0, 1'b0, px(3, 5));

        // Reset asserted mid-fill at col 200
        set_trig(2);
        step();
        vga_x = 12'd400; vga_y = 12'd0;
        video_active = 1'b1; vga_hsync = 1'b1; vga_vsync = 1'b1;
        repeat (200) step();
        chk("mr_pre_addr", 32'(fb_read_addr), addr_of(2, 200));
        chk("mr_pre_pix", 32'(pix_index), 32'(px(0, 200)));
        chk("mr_pre_active", 32'(pix_active), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rd_en", 32'(fb_read_en), 0);
        chk("mr_busy", 32'(fill_busy), 0);
        chk("mr_pix_index", 32'(pix_index), 0);
        chk("mr_pix_active", 32'(pix_active), 0);
        chk("mr_pix_hsync", 32'(pix_hsync), 0);
        chk("mr_pix_vsync", 32'(pix_vsync), 0);
        chk("mr_underrun", 32'(underrun), 0);
        chk("mr_count", 32'(underrun_count), 0);
        set_idle();
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("mr_idle_after", 32'(fb_read_en), 0);
        set_trig(0);
        step();
        set_idle();
        chk("mr_restart_en", 32'(fb_read_en), 1);
        chk("mr_restart_addr", 32'(fb_read_addr), addr_of(1, 0));
        repeat (520) step();

        // Trigger held every cycle: a long run of back-to-back underruns
        set_trig(2);
        repeat (65540) step();
        set_idle();
        step();
        chk("sat_count", 32'(underrun_count), 32'(exp_sat));
        chk("sat_flag", 32'(underrun), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
